vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_sync_pipe.sv | 42 ++++
 rtl/vga_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, counter/pixel types and helpers that
// turn porch/sync widths into terminal counts and sync bounds.
// Default 640x480@60 timing: H total 800 (sync 656..751), V total 525 (sync 490..491).
package vga_pkg;

   // Default horizontal timing in pixel periods (25 MHz pixel rate)
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   // Default vertical timing in lines
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // Both counters fit in 10 bits (800 and 525 totals)
   localparam int CNT_W = 10;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [2:0]       rgb_t;

   // One pixel's worth of monitor-side signals travelling down the pipeline
   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
      logic active;
      rgb_t rgb;
   } pix_beat_t;

   // Idle beat: syncs deasserted (high), blanked, black
   localparam pix_beat_t BEAT_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0, rgb: 3'b000};

   // Last count of a scan axis (total - 1), e.g. 799 / 524 by default
   function automatic cnt_t last_count(input int act, input int fp, input int sync, input int bp);
      return cnt_t'(act + fp + sync + bp - 1);
   endfunction

   // First count at which sync is asserted, e.g. 656 / 490 by default
   function automatic cnt_t sync_first(input int act, input int fp);
      return cnt_t'(act + fp);
   endfunction

   // Last count at which sync is asserted, e.g. 751 / 491 by default
   function automatic cnt_t sync_last(input int act, input int fp, input int sync);
      return cnt_t'(act + fp + sync - 1);
   endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// vga_sync_pipe: one-pixel delay stage for hsync/vsync/active/rgb so the
// syncs leave the block aligned with the pixel colour. Outside the active
// window rgb is forced to black.
module vga_sync_pipe
   import vga_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      pix_en_i,
   input  pix_beat_t beat_i,
   output pix_beat_t beat_o
);

   pix_beat_t beat_q;
   pix_beat_t beat_d;

   // Capture a new beat only on pixel edges; hold it across the idle clk
   always_comb begin
      beat_d = beat_q;
      if (pix_en_i) begin
         beat_d = beat_i;
      end
   end

   // Stage register, idle (syncs high, blank) while in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q <= BEAT_IDLE;
      end else begin
         beat_q <= beat_d;
      end
   end

   // Blank the colour whenever the delayed active flag is low
   always_comb begin
      beat_o = beat_q;
      if (!beat_q.active) begin
         beat_o.rgb = '0;
      end
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing from a 50 MHz clock with a 25 MHz pixel
// enable. Produces doubled-pixel coordinates for sprite logic, takes the
// returned colour one clk later and drives hsync/vsync/rgb to the monitor.
// Optional build macro VGA_TEST_PATTERN_EN replaces the colour input by eight
// vertical colour bars taken from hcount[9:7]; pipeline timing is unchanged.
//
// Colour timing contract: xvga/yvga change only on pix_en edges; color must be
// valid by the following clk edge and is sampled only on the next pix_en edge,
// so any value it takes in the first half of a pixel is ignored.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] color,
   output logic [8:0] xvga,
   output logic [7:0] yvga,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb,
   output logic       frame_start
);

   localparam cnt_t H_ACT_C    = cnt_t'(H_ACTIVE);
   localparam cnt_t V_ACT_C    = cnt_t'(V_ACTIVE);
   localparam cnt_t H_LAST_C   = last_count(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam cnt_t V_LAST_C   = last_count(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam cnt_t HS_FIRST_C = sync_first(H_ACTIVE, H_FP);
   localparam cnt_t HS_LAST_C  = sync_last(H_ACTIVE, H_FP, H_SYNC);
   localparam cnt_t VS_FIRST_C = sync_first(V_ACTIVE, V_FP);
   localparam cnt_t VS_LAST_C  = sync_last(V_ACTIVE, V_FP, V_SYNC);

   logic      pix_en_q;
   logic      pix_en_d;
   cnt_t      hcount_q;
   cnt_t      hcount_d;
   cnt_t      vcount_q;
   cnt_t      vcount_d;
   logic      frame_start_q;
   logic      frame_start_d;
   logic      h_wrap;
   logic      v_wrap;
   logic      active;
   rgb_t      pixel_src;
   pix_beat_t beat_d;
   pix_beat_t beat_out;

   // Pixel enable toggles every clk; reset leaves it low so the first pixel
   // edge is the second clk after release
   always_comb begin
      pix_en_d = ~pix_en_q;
   end

   // Raster counters advance only on pixel edges; frame_start marks the edge
   // where both wrap back to the origin
   always_comb begin
      h_wrap        = (hcount_q == H_LAST_C);
      v_wrap        = (vcount_q == V_LAST_C);
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_start_d = pix_en_q & h_wrap & v_wrap;
      if (pix_en_q) begin
         hcount_d = h_wrap ? '0 : cnt_t'(hcount_q + 1'b1);
         if (h_wrap) begin
            vcount_d = v_wrap ? '0 : cnt_t'(vcount_q + 1'b1);
         end
      end
   end

   // Timing state; asynchronous reset restarts the raster at the origin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en_q      <= 1'b0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pix_en_q      <= pix_en_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Active window, doubled-pixel coordinates (zero while blanked) and raw syncs
   always_comb begin
      active = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
      xvga   = active ? hcount_q[9:1] : '0;
      yvga   = active ? vcount_q[8:1] : '0;
      beat_d.hsync_n = !((hcount_q >= HS_FIRST_C) && (hcount_q <= HS_LAST_C));
      beat_d.vsync_n = !((vcount_q >= VS_FIRST_C) && (vcount_q <= VS_LAST_C));
      beat_d.active  = active;
      beat_d.rgb     = pixel_src;
   end

`ifdef VGA_TEST_PATTERN_EN
   rgb_t pattern_q;

   // Bar colour delayed one clk, mirroring the sprite lookup latency so the
   // pipeline samples the bar of the pixel presented one period earlier
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= '0;
      end else begin
         pattern_q <= hcount_q[9:7];
      end
   end

   assign pixel_src = pattern_q;
`else
   assign pixel_src = color;
`endif

   vga_sync_pipe u_sync_pipe (
      .clk      (clk),
      .rst      (rst),
      .pix_en_i (pix_en_q),
      .beat_i   (beat_d),
      .beat_o   (beat_out)
   );

   assign hsync       = beat_out.hsync_n;
   assign vsync       = beat_out.vsync_n;
   assign rgb         = beat_out.rgb;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: scoreboard bench for vga_scan_ctrl with reduced timing
// (H 40/4/8/8 -> 60 pixels per line, V 30/2/2/6 -> 40 lines per frame) so that
// whole frames fit in a short run. Expected values are hand-computed from the
// rule "pixel (line L, column h) reaches the outputs after clk edge
// L*120 + 2h + 2 since reset release".
module tb_vga_scan_ctrl;

   localparam int S_HS  = 0;
   localparam int S_VS  = 1;
   localparam int S_RGB = 2;
   localparam int S_FS  = 3;
   localparam int S_X   = 4;
   localparam int S_Y   = 5;
   localparam int S_ALL = 6;

   localparam logic [31:0] RST_BUNDLE = {9'd0, 1'b1, 1'b1, 3'b000, 1'b0, 9'd0, 8'd0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] color = 3'b000;
   logic [8:0] xvga;
   logic [7:0] yvga;
   logic       hsync;
   logic       vsync;
   logic [2:0] rgb;
   logic       frame_start;

   int seg = 0;
   int cyc = 0;
   int cyc_seg = 0;
   int color_mode = 0;
   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   int          seg_q[$];
   int          at_q[$];
   int          sel_q[$];

   vga_scan_ctrl #(
      .H_ACTIVE (40), .H_FP (4), .H_SYNC (8), .H_BP (8),
      .V_ACTIVE (30), .V_FP (2), .V_SYNC (2), .V_BP (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .color       (color),
      .xvga        (xvga),
      .yvga        (yvga),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .frame_start (frame_start)
   );

   // clock / reset block: 20-unit period; reset is driven by the stimulus
   always #10 clk = ~clk;

   // clk edges since the current reset segment began
   always @(posedge clk) begin
      if (seg != cyc_seg) begin
         cyc_seg <= seg;
         cyc     <= 1;
      end else begin
         cyc <= cyc + 1;
      end
   end

   function automatic int ecyc();
      return (seg == cyc_seg) ? cyc : 0;
   endfunction

   // sprite ROM model: colour as a function of the doubled-pixel column
   function automatic logic [2:0] rom(input logic [8:0] x);
      return 3'((int'(x) * 5) + 3);
   endfunction

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         S_HS:    return 32'(hsync);
         S_VS:    return 32'(vsync);
         S_RGB:   return 32'(rgb);
         S_FS:    return 32'(frame_start);
         S_X:     return 32'(xvga);
         S_Y:     return 32'(yvga);
         default: return {9'd0, hsync, vsync, rgb, frame_start, xvga, yvga};
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         S_HS:    return "hsync";
         S_VS:    return "vsync";
         S_RGB:   return "rgb";
         S_FS:    return "frame_start";
         S_X:     return "xvga";
         S_Y:     return "yvga";
         default: return "reset_outputs";
      endcase
   endfunction

   // driver tasks
   task automatic push(input int s, input int c, input int sel, input logic [31:0] e);
      seg_q.push_back(s);
      at_q.push_back(c);
      sel_q.push_back(sel);
      exp_q.push_back(e);
   endtask

   // wait for clk edge n of the current segment, then act 3 units after it
   task automatic at_edge(input int n);
      do begin
         @(posedge clk);
         #1;
      end while (!((cyc_seg == seg) && (cyc == n)));
      #2;
   endtask

   // color driver: garbage in the first half of every pixel, real value in
   // the second half (only the second half may be sampled)
   initial begin
      forever begin
         @(negedge clk);
         if ((ecyc() % 2) == 1) begin
            color = (color_mode == 1) ? rom(xvga) : 3'b101;
         end else begin
            color = (color_mode == 1) ? ~rom(xvga) : 3'b010;
         end
      end
   end

   // scoreboard monitor: pops every expectation that falls due and compares
   initial begin
      int          now;
      int          s;
      int          c;
      int          sel;
      logic [31:0] e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         now = ecyc();
         while ((exp_q.size() > 0) &&
                ((seg_q[0] < seg) || ((seg_q[0] == seg) && (at_q[0] <= now)))) begin
            s   = seg_q.pop_front();
            c   = at_q.pop_front();
            sel = sel_q.pop_front();
            e   = exp_q.pop_front();
            checks++;
            if ((s == seg) && (c == now)) begin
               act = probe(sel);
               if (act !== e) begin
                  errors++;
                  $display("FAIL %s seg%0d cyc%0d got %0h expected %0h",
                           sel_name(sel), s, c, act, e);
               end
            end else begin
               errors++;
               $display("FAIL %s seg%0d cyc%0d missed sample, expected %0h",
                        sel_name(sel), s, c, e);
            end
         end
      end
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog timeout, got no finish required finish");
      $fatal(1, "timeout");
   end

   // stimulus
   initial begin
      // segment 0: reset held 10 clk
      for (int c = 1; c <= 9; c++) push(0, c, S_ALL, RST_BUNDLE);
      // segment 1: free run from release
      push(1, 0,    S_ALL, RST_BUNDLE);
      push(1, 1,    S_RGB, 32'h0);
      push(1, 2,    S_RGB, 32'h5);
      push(1, 3,    S_X,   32'd0);
      push(1, 4,    S_X,   32'd1);
      push(1, 81,   S_RGB, 32'h5);
      push(1, 82,   S_RGB, 32'h0);
      push(1, 89,   S_HS,  32'd1);
      push(1, 90,   S_HS,  32'd0);
      push(1, 105,  S_HS,  32'd0);
      push(1, 106,  S_HS,  32'd1);
      push(1, 121,  S_RGB, 32'h0);
      push(1, 122,  S_RGB, 32'h5);
      push(1, 209,  S_HS,  32'd1);
      push(1, 210,  S_HS,  32'd0);
      push(1, 410,  S_X,   32'd12);
      push(1, 410,  S_Y,   32'd1);
      push(1, 460,  S_X,   32'd0);
      push(1, 460,  S_Y,   32'd0);
      push(1, 3502, S_RGB, 32'h5);
      push(1, 3558, S_X,   32'd19);
      push(1, 3558, S_Y,   32'd14);
      push(1, 3622, S_RGB, 32'h0);
      push(1, 3841, S_VS,  32'd1);
      push(1, 3842, S_VS,  32'd0);
      push(1, 4081, S_VS,  32'd0);
      push(1, 4082, S_VS,  32'd1);
      push(1, 4220, S_X,   32'd0);
      push(1, 4220, S_Y,   32'd0);
      push(1, 4702, S_RGB, 32'h0);
      push(1, 4799, S_FS,  32'd0);
      push(1, 4800, S_FS,  32'd1);
      push(1, 4801, S_FS,  32'd0);
      push(1, 4822, S_RGB, 32'h5);
      // ROM-driven line: frame 2, line 1, every active column
      for (int h = 0; h < 40; h++) begin
         push(1, 4922 + 2 * h, S_RGB, 32'(rom(9'(h >> 1))));
      end
      push(1, 7250, S_X,   32'd12);
      push(1, 7250, S_Y,   32'd10);
      push(1, 7251, S_RGB, 32'h5);
      // segment 2: asynchronous reset mid-frame (line 20, column 25)
      for (int c = 0; c <= 2; c++) push(2, c, S_ALL, RST_BUNDLE);
      // segment 3: restart from the origin
      push(3, 0,    S_ALL, RST_BUNDLE);
      push(3, 1,    S_RGB, 32'h0);
      push(3, 2,    S_RGB, 32'h5);
      push(3, 4,    S_X,   32'd1);
      push(3, 89,   S_HS,  32'd1);
      push(3, 90,   S_HS,  32'd0);
      push(3, 4800, S_FS,  32'd1);
      push(3, 4801, S_FS,  32'd0);

      rst = 1'b1;
      at_edge(10);
      rst = 1'b0;
      seg = 1;
      at_edge(4900);
      color_mode = 1;
      at_edge(5100);
      color_mode = 0;
      at_edge(7252);
      rst = 1'b1;
      seg = 2;
      at_edge(3);
      rst = 1'b0;
      seg = 3;
      at_edge(4810);
      repeat (2) @(negedge clk);
      #1;

      // final report
      while (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s seg%0d cyc%0d never sampled, expected %0h",
                  sel_name(sel_q[0]), seg_q[0], at_q[0], exp_q[0]);
         void'(seg_q.pop_front());
         void'(at_q.pop_front());
         void'(sel_q.pop_front());
         void'(exp_q.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
